// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder:
//   CLA_GRP        - lookahead group width (bits per group)
//   CLA_WIDTH      - datapath width the stage-1 payload struct is sized for
//   CLA_NGRP       - number of lookahead groups at CLA_WIDTH
//   cla_num_groups - derives the group count from an operand width
//   cla_s1_t       - stage-1 pipeline payload (h, g, p, GG, GP, c0)
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_GRP   = 4;
  localparam int CLA_WIDTH = 32;

  function automatic int cla_num_groups(input int width);
    return width / CLA_GRP;
  endfunction

  localparam int CLA_NGRP = cla_num_groups(CLA_WIDTH);

  // Everything stage 2 needs to finish the add: per-bit half-sum, generate
  // and propagate, per-group generate/propagate and the conditioned carry-in.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] h;
    logic [CLA_WIDTH-1:0] g;
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_NGRP-1:0]  gg;
    logic [CLA_NGRP-1:0]  gp;
    logic                 c0;
  } cla_s1_t;

endpackage

// File: rtl/cla_gp_cell.sv
// -----------------------------------------------------------------------------
// cla_gp_cell
// 1-bit generate/propagate adder cell.
//   a, b  in  operand bits
//   c_in  in  carry in
//   s     out a ^ b ^ c_in (equals the half-sum h when c_in is tied low)
//   g     out generate, a & b
//   p     out propagate, a | b
// -----------------------------------------------------------------------------
module cla_gp_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic g,
  output logic p
);

  assign s = a ^ b ^ c_in;
  assign g = a & b;
  assign p = a | b;

endmodule

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Combinational 4-bit carry-lookahead group.
//   g[3:0], p[3:0]  in  per-bit generate / propagate
//   cin             in  carry into bit 0 of the group
//   gg              out group generate
//   gp              out group propagate
//   c[3:1]          out carries into bits 1..3 of the group
// Propagate may be either a|b or a^b; both give the same carries.
// -----------------------------------------------------------------------------
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic       gg,
  output logic       gp,
  output logic [3:1] c
);

  assign c[1] = g[0]
              | (p[0] & cin);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign gp = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides and one operation per cycle throughput.
//   Stage 1: operand conditioning, per-bit h/g/p and per-group GG/GP.
//   Stage 2: group carry ripple, in-group lookahead carries, sum, c_out, zero.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  stage 1 can accept this cycle (combinational from out_ready)
//   a, b       in   operands (WIDTH bits)
//   c_in       in   carry in, ignored when sub=1
//   sub        in   1: a - b computed as a + ~b + 1
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   sum        out  result (WIDTH bits, modulo 2^WIDTH)
//   c_out      out  carry out of the MSB; for sub, 1 means no borrow
//   zero       out  sum == 0
//   ovf        out  signed overflow (only when CLA_OVF_EN is defined)
//
// Build option: define CLA_OVF_EN to add the ovf port, the operand MSB
// pipeline registers and the overflow logic.
// -----------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             zero
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGRP = cla_num_groups(WIDTH);

  // Width checks at elaboration. The stage-1 payload type lives in the
  // package, so the width must match the width the struct was sized for.
  generate
    if (WIDTH % CLA_GRP != 0) begin : g_bad_width_mod
      $error("cla_pipe_adder: WIDTH must be a multiple of 4");
    end
    if (WIDTH != CLA_WIDTH) begin : g_bad_width_pkg
      $error("cla_pipe_adder: WIDTH must equal cla_pkg::CLA_WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic adv1, adv2, accept;

  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & adv1;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: operand conditioning and G/P generation
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] h1, g1, p1;
  logic [NGRP-1:0]  gg1, gp1;
  logic [NGRP-1:0][3:1] s1_c_unused;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : c_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_cell
      // Carry-in tied low so the cell's sum is the plain half-sum a ^ b_eff.
      cla_gp_cell u_cell (
        .a    (a[gi]),
        .b    (b_eff[gi]),
        .c_in (1'b0),
        .s    (h1[gi]),
        .g    (g1[gi]),
        .p    (p1[gi])
      );
    end

    for (gi = 0; gi < NGRP; gi++) begin : g_s1_group
      // Only GG/GP are wanted here; the in-group carries are recomputed in
      // stage 2 once the real group carry-in is known.
      cla_group4 u_grp (
        .g   (g1[CLA_GRP*gi +: CLA_GRP]),
        .p   (p1[CLA_GRP*gi +: CLA_GRP]),
        .cin (1'b0),
        .gg  (gg1[gi]),
        .gp  (gp1[gi]),
        .c   (s1_c_unused[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  cla_s1_t s1_q, s1_d;
`ifdef CLA_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
`ifdef CLA_OVF_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
`endif
    if (adv1) begin
      s1_valid_d = in_valid;
    end
    // Payload only loads on a real accept; an idle advance leaves stale
    // data behind a cleared valid.
    if (accept) begin
      s1_d.h  = h1;
      s1_d.g  = g1;
      s1_d.p  = p1;
      s1_d.gg = gg1;
      s1_d.gp = gp1;
      s1_d.c0 = c0;
`ifdef CLA_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
`ifdef CLA_OVF_EN
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
`ifdef CLA_OVF_EN
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: group carry ripple, bit carries, sum
  // ---------------------------------------------------------------------------
  logic [NGRP:0]        grp_c;
  logic [WIDTH-1:0]     bit_c;
  logic [WIDTH-1:0]     sum_c;
  logic [NGRP-1:0][3:1] s2_c;
  logic [NGRP-1:0]      s2_gg_unused, s2_gp_unused;

  // Group carries ripple one group per step: C_{j+1} = GG_j | GP_j & C_j.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_q.c0;
    for (int j = 0; j < NGRP; j++) begin
      grp_c[j+1] = s1_q.gg[j] | (s1_q.gp[j] & grp_c[j]);
    end
  end

  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_s2_group
      cla_group4 u_grp (
        .g   (s1_q.g[CLA_GRP*gi +: CLA_GRP]),
        .p   (s1_q.p[CLA_GRP*gi +: CLA_GRP]),
        .cin (grp_c[gi]),
        .gg  (s2_gg_unused[gi]),
        .gp  (s2_gp_unused[gi]),
        .c   (s2_c[gi])
      );
      assign bit_c[CLA_GRP*gi]         = grp_c[gi];
      assign bit_c[CLA_GRP*gi+1 +: 3]  = s2_c[gi];
    end
  endgenerate

  assign sum_c = s1_q.h ^ bit_c;

  // ---------------------------------------------------------------------------
  // Stage 2 registers (output)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
`ifdef CLA_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    zero_d      = zero_q;
`ifdef CLA_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (adv2) begin
      out_valid_d = s1_valid_q;
      // Result registers only move for a real beat, so they stay put while
      // the output is stalled and are not scribbled by bubbles.
      if (s1_valid_q) begin
        sum_d   = sum_c;
        c_out_d = grp_c[NGRP];
        zero_d  = (sum_c == '0);
`ifdef CLA_OVF_EN
        ovf_d   = (a_msb_q == b_msb_q) & (sum_c[WIDTH-1] != a_msb_q);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b0;
`ifdef CLA_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      zero_q      <= zero_d;
`ifdef CLA_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;
`ifdef CLA_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
